// File: rtl/demux_defs.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
package demux_defs;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register with valid/ready drain and a completed-transfer counter.
module demux_slot
  import demux_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             can_load,
  output logic [CNT_W-1:0] count
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // A load while draining keeps the slot full and replaces the word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    drain_c = (state_q == ST_FULL) && out_ready;
    if (drain_c) begin
      count_d = count_q + CNT_W'(1);
    end
    if (load) begin
      state_d = ST_FULL;
      data_d  = load_data;
    end else if (drain_c) begin
      state_d = ST_EMPTY;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign can_load  = (state_q == ST_EMPTY) || out_ready;
  assign count     = count_q;

endmodule

// File: rtl/demux_4_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into holding slot A or B.
module demux_4_reg
  import demux_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic a_can_load, b_can_load;
  logic accept, a_load, b_load;

  // Readiness depends only on the selected slot, never on in_valid.
  assign in_ready = (in_sel == SEL_B) ? b_can_load : a_can_load;
  assign accept   = in_valid && in_ready;
  assign a_load   = accept && (in_sel == SEL_A);
  assign b_load   = accept && (in_sel == SEL_B);

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (a_load),
    .load_data (in_data),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .can_load  (a_can_load),
    .count     (a_count)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (b_load),
    .load_data (in_data),
    .out_data  (b_data),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .can_load  (b_can_load),
    .count     (b_count)
  );

endmodule
